// File: rtl/program_loader_if.sv
// Byte-stream handshake plus instruction-memory write port between the
// boot loader (slave) and its byte source / CPU memory side (master).
interface program_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] instruction_out;
    logic [15:0] load_address;
    logic        load_instruction;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  instruction_out,
        input  load_address,
        input  load_instruction
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output instruction_out,
        output load_address,
        output load_instruction
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: assembles big-endian words from a byte stream, writes them into CPU
// instruction memory and holds the CPU in reset until done. Optional: LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic            clk,
    input  logic            pc_reset,
    program_loader_if.slave bus,
    input  logic            reload,
    output logic            cpu_reset,
    output logic            done,
    output logic            error
);
    typedef enum logic [2:0] {
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_RUN,
        ST_ERR
`ifdef LOADER_CHECKSUM_EN
        , ST_CHECK
`endif
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_LAST = ST_CHECK;
`else
    localparam state_t ST_LAST = ST_RUN;
`endif

    state_t      state_reg, state_next;
    logic [7:0]  cnt_hi_reg;
    logic [7:0]  hi_byte_reg;
    logic [15:0] count_reg;
    logic [15:0] index_reg;
    logic [15:0] instr_reg;
    logic [15:0] addr_reg;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_reg;
`endif

    logic        byte_ready;
    logic        accept;
    logic [15:0] count_word;
    logic [15:0] index_inc;

    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            state_reg <= ST_CNT_HI;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        byte_ready = 1'b0;
        count_word = {cnt_hi_reg, bus.byte_in};
        index_inc  = index_reg + 16'd1;
        case (state_reg)
            ST_CNT_HI, ST_CNT_LO, ST_DATA_HI, ST_DATA_LO: byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: byte_ready = 1'b1;
`endif
            default: byte_ready = 1'b0;
        endcase
        // byte_ready depends on state only, so accept never feeds an output directly
        accept = bus.byte_valid & byte_ready;

        case (state_reg)
            ST_CNT_HI:  if (accept) state_next = ST_CNT_LO;
            ST_CNT_LO: begin
                if (accept) begin
                    if (32'(count_word) > DEPTH) state_next = ST_ERR;
                    else if (count_word == 16'd0) state_next = ST_LAST;
                    else state_next = ST_DATA_HI;
                end
            end
            ST_DATA_HI: if (accept) state_next = ST_DATA_LO;
            ST_DATA_LO: if (accept) state_next = ST_WRITE;
            ST_WRITE:   state_next = (index_inc < count_reg) ? ST_DATA_HI : ST_LAST;
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept) state_next = (bus.byte_in == csum_reg) ? ST_RUN : ST_ERR;
            end
`endif
            ST_RUN, ST_ERR: if (reload) state_next = ST_CNT_HI;
            default:    state_next = ST_CNT_HI;
        endcase
    end

    // Word and address are captured with the low byte so they are stable for the whole WRITE cycle
    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            cnt_hi_reg  <= 8'd0;
            hi_byte_reg <= 8'd0;
            count_reg   <= 16'd0;
            index_reg   <= 16'd0;
            instr_reg   <= 16'd0;
            addr_reg    <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            csum_reg    <= 8'd0;
`endif
        end else begin
            case (state_reg)
                ST_CNT_HI:  if (accept) cnt_hi_reg <= bus.byte_in;
                ST_CNT_LO:  if (accept) count_reg <= count_word;
                ST_DATA_HI: begin
                    if (accept) begin
                        hi_byte_reg <= bus.byte_in;
`ifdef LOADER_CHECKSUM_EN
                        csum_reg    <= csum_reg ^ bus.byte_in;
`endif
                    end
                end
                ST_DATA_LO: begin
                    if (accept) begin
                        instr_reg <= {hi_byte_reg, bus.byte_in};
                        addr_reg  <= BASE_ADDR + index_reg;
`ifdef LOADER_CHECKSUM_EN
                        csum_reg  <= csum_reg ^ bus.byte_in;
`endif
                    end
                end
                ST_WRITE:   index_reg <= index_inc;
                ST_RUN, ST_ERR: begin
                    if (reload) begin
                        cnt_hi_reg <= 8'd0;
                        count_reg  <= 16'd0;
                        index_reg  <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
                        csum_reg   <= 8'd0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready       = byte_ready;
    assign bus.instruction_out  = instr_reg;
    assign bus.load_address     = addr_reg;
    assign bus.load_instruction = (state_reg == ST_WRITE);
    assign done                 = (state_reg == ST_RUN);
    assign error                = (state_reg == ST_ERR);
    assign cpu_reset            = (state_reg != ST_RUN);
endmodule

// File: tb/tb_program_loader.sv
// Table-driven bench for program_loader: streams are replayed from a vector table,
// expected memory writes go through a scoreboard queue checked by a write monitor.
`timescale 1ns/1ps
module tb_program_loader;
    localparam int unsigned DEPTH     = 256;
    localparam logic [15:0] BASE_ADDR = 16'h0000;
`ifdef LOADER_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    typedef struct packed {
        logic [0:7][7:0] b;
        logic [3:0]      nb;
        logic [3:0]      gap_max;
        logic            exp_done;
        logic            exp_error;
        logic [7:0]      exp_writes;
    } vec_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic pc_reset;
    logic reload;
    logic cpu_reset;
    logic done;
    logic error;

    program_loader_if bus();

    program_loader #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk       (clk),
        .pc_reset  (pc_reset),
        .bus       (bus),
        .reload    (reload),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   errors   = 0;
    int   wr_count = 0;
    int   cyc      = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkvec(input logic [63:0] bytes, input int nb, input int gap,
                                   input logic d, input logic e, input int w);
        vec_t v;
        v.b          = bytes;
        v.nb         = 4'(nb);
        v.gap_max    = 4'(gap);
        v.exp_done   = d;
        v.exp_error  = e;
        v.exp_writes = 8'(w);
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Write monitor: every strobe must match the oldest expected write
    initial forever begin
        @(negedge clk);
        if (bus.load_instruction === 1'b1) begin
            wr_count++;
            $display("write addr=%h data=%h", bus.load_address, bus.instruction_out);
            check("write_ready_low", 32'(bus.byte_ready), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, want no write",
                         bus.load_address, bus.instruction_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(bus.load_address), 32'(mon_e.addr));
                check("write_data", 32'(bus.instruction_out), 32'(mon_e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        for (int g = 0; g < gap; g++) @(negedge clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (bus.byte_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (bus.byte_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte %h got byte_ready=%b, want 1", b, bus.byte_ready);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_end();
        int waited;
        waited = 0;
        while (!(done === 1'b1 || error === 1'b1) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic run_stream(input vec_t v, input int idx);
        int n;
        int first_cyc;
        n = int'({v.b[0], v.b[1]});
        first_cyc = 0;
        wr_count = 0;
        for (int i = 0; i < int'(v.nb); i++) begin
            if (i >= 3 && (i % 2) == 1 && i < 2 + 2 * n && n <= int'(DEPTH))
                exp_q.push_back({BASE_ADDR + 16'((i - 2) / 2), v.b[i-1], v.b[i]});
            send_byte(v.b[i], (v.gap_max == 4'd0) ? 0 : int'($urandom_range(0, int'(v.gap_max))));
            if (i == 0) first_cyc = cyc;
        end
        wait_end();
        $display("stream %0d: done=%b error=%b writes=%0d", idx, done, error, wr_count);
        check("done", 32'(done), 32'(v.exp_done));
        check("error", 32'(error), 32'(v.exp_error));
        check("cpu_reset", 32'(cpu_reset), 32'(!v.exp_done));
        check("byte_ready_idle", 32'(bus.byte_ready), 32'd0);
        check("write_count", 32'(wr_count), 32'(v.exp_writes));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        if (v.gap_max == 4'd0 && v.exp_done)
            check("cycles_to_run", 32'(cyc - first_cyc), 32'(1 + 3 * n + CSUM));
        exp_q.delete();
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        $display("reload: byte_ready=%b cpu_reset=%b", bus.byte_ready, cpu_reset);
        check("reload_ready", 32'(bus.byte_ready), 32'd1);
        check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        check("reload_done", 32'(done), 32'd0);
        check("reload_error", 32'(error), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        $display("%s: ready=%b cpu_reset=%b strobe=%b instr=%h addr=%h done=%b error=%b", tag,
                 bus.byte_ready, cpu_reset, bus.load_instruction, bus.instruction_out,
                 bus.load_address, done, error);
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd1);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_load_instruction", 32'(bus.load_instruction), 32'd0);
        check("rst_instruction_out", 32'(bus.instruction_out), 32'd0);
        check("rst_load_address", 32'(bus.load_address), 32'(BASE_ADDR));
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
    endtask

    initial begin
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] csum;

        pc_reset       = 1'b1;
        reload         = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        pc_reset = 1'b0;

`ifdef LOADER_CHECKSUM_EN
        vecs[0] = mkvec({8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00}, 7, 0, 1'b1, 1'b0, 2);
        vecs[1] = mkvec({8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00}, 7, 3, 1'b1, 1'b0, 2);
        vecs[2] = mkvec({8'h00, 8'h00, 8'h00, 40'h0}, 3, 0, 1'b1, 1'b0, 0);
        vecs[3] = mkvec({8'h01, 8'h01, 48'h0}, 2, 0, 1'b0, 1'b1, 0);
        vecs[4] = mkvec({8'h00, 8'h01, 8'h12, 8'h34, 8'h26, 24'h0}, 5, 0, 1'b1, 1'b0, 1);
        vecs[5] = mkvec({8'h00, 8'h01, 8'h12, 8'h34, 8'h27, 24'h0}, 5, 0, 1'b0, 1'b1, 1);
        vecs[6] = mkvec({8'h00, 8'h00, 8'h01, 40'h0}, 3, 0, 1'b0, 1'b1, 0);
`else
        vecs[0] = mkvec({8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 16'h0}, 6, 0, 1'b1, 1'b0, 2);
        vecs[1] = mkvec({8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 16'h0}, 6, 3, 1'b1, 1'b0, 2);
        vecs[2] = mkvec({8'h00, 8'h00, 48'h0}, 2, 0, 1'b1, 1'b0, 0);
        vecs[3] = mkvec({8'h01, 8'h01, 48'h0}, 2, 0, 1'b0, 1'b1, 0);
        vecs[4] = mkvec({8'h00, 8'h01, 8'h12, 8'h34, 32'h0}, 4, 0, 1'b1, 1'b0, 1);
        vecs[5] = mkvec({8'h80, 8'h00, 48'h0}, 2, 0, 1'b0, 1'b1, 0);
        vecs[6] = mkvec({8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 8, 1, 1'b1, 1'b0, 3);
`endif

        for (int v = 0; v < 7; v++) begin
            run_stream(vecs[v], v);
            if (v == 0) begin
                check("hold_instruction_out", 32'(bus.instruction_out), 32'h0000ABCD);
                check("hold_load_address", 32'(bus.load_address), 32'(BASE_ADDR + 16'd1));
                check("hold_strobe_low", 32'(bus.load_instruction), 32'd0);
            end
            do_reload();
        end

        // reload outside RUN/ERR must not disturb a load in progress
        wr_count = 0;
        send_byte(8'h00, 0);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("reload_ignored_ready", 32'(bus.byte_ready), 32'd1);
        exp_q.push_back({BASE_ADDR, 16'h5A5A});
        send_byte(8'h01, 0);
        send_byte(8'h5A, 0);
        send_byte(8'h5A, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        wait_end();
        $display("reload-ignored stream: done=%b writes=%0d", done, wr_count);
        check("reload_ignored_done", 32'(done), 32'd1);
        check("reload_ignored_writes", 32'(wr_count), 32'd1);
        exp_q.delete();
        do_reload();

        // largest legal image: exactly DEPTH words
        wr_count = 0;
        csum = 8'h00;
        send_byte(8'(DEPTH >> 8), 0);
        send_byte(8'(DEPTH), 0);
        for (int w = 0; w < int'(DEPTH); w++) begin
            hi = 8'($urandom);
            lo = 8'($urandom);
            csum = csum ^ hi ^ lo;
            send_byte(hi, 0);
            exp_q.push_back({BASE_ADDR + 16'(w), hi, lo});
            send_byte(lo, 0);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum, 0);
`endif
        wait_end();
        $display("depth stream: done=%b error=%b writes=%0d", done, error, wr_count);
        check("depth_done", 32'(done), 32'd1);
        check("depth_writes", 32'(wr_count), 32'(DEPTH));
        check("depth_last_addr", 32'(bus.load_address), 32'(BASE_ADDR + 16'(DEPTH - 1)));
        exp_q.delete();
        do_reload();

        // asynchronous abort mid-load, then a clean reload from scratch
        wr_count = 0;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        exp_q.push_back({BASE_ADDR, 16'h1234});
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        #2;
        pc_reset = 1'b1;
        #1;
        check_reset_values("abort");
        check("abort_partial_write", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        pc_reset = 1'b0;
        run_stream(vecs[0], 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader sitting directly upstream of the 16-bit single-cycle CPU. It receives a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. Each word is written into the CPU's instruction memory through the CPU's `instruction_in`/`load_address`/`load_instruction` port, and the CPU is held in reset until the image is complete. When the load finishes it releases the CPU to run from address `BASE_ADDR`.

## Interface
- `DEPTH`, 256: maximum image size in words; a larger header count is an error.
- `BASE_ADDR`, 16'h0000: instruction-memory address of the first word.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `pc_reset`  input  1  asynchronous, active-high reset.
- `byte_in`  input  8  stream data byte.
- `byte_valid`  input  1  `byte_in` valid.
- `byte_ready`  output  1  loader can accept a byte this cycle.
- `reload`  input  1  single-cycle request to restart loading from `RUN` or `ERR`.
- `instruction_out`  output  16  word to the CPU's `instruction_in`.
- `load_address`  output  16  address to the CPU's `load_address`.
- `load_instruction`  output  1  one-cycle write strobe to the CPU's `load_instruction`.
- `cpu_reset`  output  1  drives the CPU's `pc_reset`; high while not in `RUN`.
- `done`  output  1  high in `RUN`.
- `error`  output  1  high in `ERR`.

## Operation
- Stream format: `CNT_HI`, `CNT_LO` (16-bit word count N), then N words sent high byte first. With checksum enabled, one trailing checksum byte follows.
- States: `CNT_HI` → `CNT_LO` → (`DATA_HI` → `DATA_LO` → `WRITE`)×N → [`CHECK`] → `RUN`; error exit to `ERR`.
- A byte is accepted on an edge where `byte_valid & byte_ready` is true. Each accept advances the state.
- `byte_ready` = 1 in `CNT_HI`, `CNT_LO`, `DATA_HI`, `DATA_LO`, `CHECK`; 0 in `WRITE`, `RUN`, `ERR`.
- In `CNT_LO`, after accepting the byte:
  - N > `DEPTH` → `ERR`.
  - N = 0 → `CHECK` if checksum is enabled, else `RUN`.
  - Otherwise → `DATA_HI`.
- `WRITE` lasts exactly one cycle. In it: `load_instruction` = 1, `instruction_out` = the assembled word, `load_address` = `BASE_ADDR` + word index (16-bit wrap).
- Word index increments on leaving `WRITE`. The state returns to `DATA_HI` while index < N; otherwise it goes to `CHECK` or `RUN`.
- `RUN` and `ERR` are held until `reload` = 1. `reload` clears the index, count and checksum and goes to `CNT_HI`; `cpu_reset` reasserts the next cycle. `reload` in any other state is ignored.
- `instruction_out` and `load_address` hold their last values outside `WRITE`. `load_instruction` = 0 outside `WRITE`.

## Timing
- Reset values: state `CNT_HI`, `byte_ready` = 1, `cpu_reset` = 1, `load_instruction` = 0, `instruction_out` = 0, `load_address` = `BASE_ADDR`, `done` = 0, `error` = 0, index = 0.
- `pc_reset` asserted mid-load aborts immediately. A partial image stays in instruction memory, but the CPU remains in reset.
- All outputs are registered or decoded from the state register only. There is no combinational path from `byte_valid` to any output.
- Minimum of 3 cycles per word (2 accepts + `WRITE`). Minimum total is 2 + 3N (+1 with checksum) cycles from the first accept to `RUN`.
- `cpu_reset` falls on the same edge that enters `RUN`. The CPU fetches from `BASE_ADDR` on the following edge.
- Gaps in `byte_valid` stall any receive state indefinitely; there is no timeout.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - Adds the `CHECK` state and an 8-bit running XOR over all data bytes (header excluded).
  - The trailing byte is compared against the running XOR. A match goes to `RUN`; a mismatch goes to `ERR` with the CPU kept in reset.
- Undefined: no `CHECK` state and no checksum logic; the state goes to `RUN` directly after the last `WRITE`.

## Test plan
- Reset, stream 00 02 12 34 AB CD (checksum off):
  - Writes 16'h1234 at address 0, then 16'hABCD at address 1, one strobe each.
  - `done` = 1 and `cpu_reset` = 0 on the edge after the second `WRITE`.
- Stream 00 00 → `RUN` after 2 accepts with no `load_instruction` pulse. With checksum on, 00 00 00 is required and reaches `RUN`.
- Stream 01 01 (N = 257, `DEPTH` = 256) → `error` = 1, `byte_ready` = 0, `cpu_reset` stays 1. Then pulse `reload` → `CNT_HI`.
- Checksum on, stream 00 01 12 34 26 → `RUN`. Stream 00 01 12 34 27 → `ERR`.
- Random `byte_valid` gaps on the first test's stream → identical writes and addresses. `byte_ready` = 0 during every `WRITE`.
- Assert `pc_reset` after the `DATA_HI` byte of word 1 → all outputs return to reset values asynchronously. A full restream then loads correctly from address 0.
